// File: rtl/wash_pkg.sv
// -----------------------------------------------------------------------------
// wash_pkg -- shared definitions for the washing-machine sequencer.
//   wash_state_e : sequencer states (IDLE, FWD, STOP1, REV, STOP2, SPIN, DONE)
//   MOTOR_*      : 2-bit motor drive codes
//   motor_code() : motor code that a state drives when not paused
//   is_busy()    : true for every state except IDLE and DONE
//   max_int()    : integer max, used to size the phase counter
// -----------------------------------------------------------------------------
package wash_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FWD   = 3'd1,
        ST_STOP1 = 3'd2,
        ST_REV   = 3'd3,
        ST_STOP2 = 3'd4,
        ST_SPIN  = 3'd5,
        ST_DONE  = 3'd6
    } wash_state_e;

    localparam logic [1:0] MOTOR_STOP = 2'b00;
    localparam logic [1:0] MOTOR_FWD  = 2'b01;
    localparam logic [1:0] MOTOR_REV  = 2'b10;
    localparam logic [1:0] MOTOR_SPIN = 2'b11;

    function automatic logic [1:0] motor_code(input wash_state_e s);
        logic [1:0] m;
        m = MOTOR_STOP;
        case (s)
            ST_FWD:  m = MOTOR_FWD;
            ST_REV:  m = MOTOR_REV;
            ST_SPIN: m = MOTOR_SPIN;
            default: m = MOTOR_STOP;
        endcase
        return m;
    endfunction

    function automatic logic is_busy(input wash_state_e s);
        return !((s == ST_IDLE) || (s == ST_DONE));
    endfunction

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/sec_tick.sv
// -----------------------------------------------------------------------------
// sec_tick -- one-second prescaler.
//   Counts enabled clocks and raises tick (combinational, one cycle) on the
//   CLK_HZ-th enabled clock, then wraps. clr forces the count back to zero and
//   suppresses tick. Holding en low freezes the count, so a paused run resumes
//   mid-second exactly where it stopped.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : synchronous clear of the count
//   en         : count enable (unpaused running clock)
//   tick       : end-of-second strobe
// -----------------------------------------------------------------------------
module sec_tick #(
    parameter int CLK_HZ = 40000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int CW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLK_HZ - 1);

    logic [CW-1:0] cnt;

    assign tick = en && !clr && (cnt == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= (cnt == LAST) ? '0 : cnt + CW'(1);
        end
    end

endmodule

// File: rtl/wash_seq_ctrl.sv
// -----------------------------------------------------------------------------
// wash_seq_ctrl -- washing-machine wash-cycle sequencer.
//   A rising start edge in IDLE/DONE (wash_time != 0) begins a run that cycles
//   FWD -> STOP1 -> REV -> STOP2 -> FWD, one second per prescaler tick, until
//   the wash-seconds budget runs out, then goes to DONE (or through SPIN first
//   when WASH_SPIN_EN is defined). pause freezes everything, abort cancels.
//   All outputs are registered.
// Build option:
//   WASH_SPIN_EN : when defined, a SPIN_S-second spin (motor 11) follows the
//                  wash; when undefined the run ends straight in DONE.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : run request, rising edge only
//   pause      : level, freezes the run
//   abort      : level, cancels the run (highest priority)
//   wash_time  : wash seconds, sampled on the accepted start edge
//   motor      : 00 stop, 01 forward, 10 reverse, 11 spin
//   compl_n    : low in DONE until the next accepted start or abort
//   busy       : high in every state but IDLE/DONE
//   remain     : wash seconds left
// -----------------------------------------------------------------------------
module wash_seq_ctrl
    import wash_pkg::*;
#(
    parameter int CLK_HZ = 40000,
    parameter int TW     = 12,
    parameter int FWD_S  = 20,
    parameter int STOP_S = 10,
    parameter int REV_S  = 20,
    parameter int SPIN_S = 30
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          pause,
    input  logic          abort,
    input  logic [TW-1:0] wash_time,
    output logic [1:0]    motor,
    output logic          compl_n,
    output logic          busy,
    output logic [TW-1:0] remain
);

    // Phase counter is sized for the longest phase, spin included.
    localparam int PMAX = max_int(max_int(FWD_S, STOP_S), max_int(REV_S, SPIN_S));
    localparam int PW   = $clog2(PMAX + 1);

    wash_state_e   state, state_nx;
    logic [PW-1:0] phase_cnt, phase_nx;
    logic [TW-1:0] remain_nx;
    logic [1:0]    motor_nx;
    logic          compl_nx;
    logic          busy_nx;
    logic          start_q;
    logic          start_rise;
    logic          tick;
    logic          tick_en;
    logic          presc_clr;

    assign start_rise = start && !start_q;

    // Only unpaused, un-aborted clocks in a running state count toward a second.
    assign tick_en = is_busy(state) && !pause && !abort;

    sec_tick #(
        .CLK_HZ (CLK_HZ)
    ) u_sec_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (presc_clr),
        .en    (tick_en),
        .tick  (tick)
    );

    always_comb begin
        state_nx  = state;
        phase_nx  = phase_cnt;
        remain_nx = remain;
        compl_nx  = compl_n;
        presc_clr = 1'b0;

        if (abort) begin
            state_nx  = ST_IDLE;
            phase_nx  = '0;
            remain_nx = '0;
            compl_nx  = 1'b1;
            presc_clr = 1'b1;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    // Keep the prescaler at zero so a new run starts on a
                    // full second.
                    presc_clr = 1'b1;
                    if (start_rise && (wash_time != '0)) begin
                        state_nx  = ST_FWD;
                        phase_nx  = PW'(FWD_S);
                        remain_nx = wash_time;
                        compl_nx  = 1'b1;
                    end
                end
                ST_SPIN: begin
                    if (tick) begin
                        if (phase_cnt == PW'(1)) begin
                            state_nx = ST_DONE;
                            phase_nx = '0;
                            compl_nx = 1'b0;
                        end else begin
                            phase_nx = phase_cnt - PW'(1);
                        end
                    end
                end
                default: begin
                    if (tick) begin
                        remain_nx = remain - TW'(1);
                        // Running out of wash time ends the run from any phase.
                        if (remain == TW'(1)) begin
`ifdef WASH_SPIN_EN
                            state_nx = ST_SPIN;
                            phase_nx = PW'(SPIN_S);
`else
                            state_nx = ST_DONE;
                            phase_nx = '0;
                            compl_nx = 1'b0;
`endif
                        end else if (phase_cnt == PW'(1)) begin
                            case (state)
                                ST_FWD:   begin state_nx = ST_STOP1; phase_nx = PW'(STOP_S); end
                                ST_STOP1: begin state_nx = ST_REV;   phase_nx = PW'(REV_S);  end
                                ST_REV:   begin state_nx = ST_STOP2; phase_nx = PW'(STOP_S); end
                                default:  begin state_nx = ST_FWD;   phase_nx = PW'(FWD_S);  end
                            endcase
                        end else begin
                            phase_nx = phase_cnt - PW'(1);
                        end
                    end
                end
            endcase
        end

        busy_nx  = is_busy(state_nx);
        // A paused run keeps its state but the motor is held stopped.
        motor_nx = (pause && busy_nx) ? MOTOR_STOP : motor_code(state_nx);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            phase_cnt <= '0;
            remain    <= '0;
            motor     <= MOTOR_STOP;
            compl_n   <= 1'b1;
            busy      <= 1'b0;
            start_q   <= 1'b0;
        end else begin
            state     <= state_nx;
            phase_cnt <= phase_nx;
            remain    <= remain_nx;
            motor     <= motor_nx;
            compl_n   <= compl_nx;
            busy      <= busy_nx;
            start_q   <= start;
        end
    end

endmodule

// File: tb/tb_wash_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_wash_seq_ctrl -- self-checking bench for wash_seq_ctrl.
//   The reference model tracks a run as "unpaused clocks since start"; the
//   elapsed second count then gives the phase (position in the forward/stop/
//   reverse/stop cycle), the seconds left and whether spin or done is reached.
//   Honours WASH_SPIN_EN the same way the design does.
// -----------------------------------------------------------------------------
module tb_wash_seq_ctrl;

    localparam int CLK_HZ = 4;
    localparam int TW     = 12;
    localparam int FWD_S  = 2;
    localparam int STOP_S = 1;
    localparam int REV_S  = 2;
    localparam int SPIN_S = 3;
    localparam int CYC_S  = FWD_S + STOP_S + REV_S + STOP_S;
`ifdef WASH_SPIN_EN
    localparam int SPIN_LEN = SPIN_S;
`else
    localparam int SPIN_LEN = 0;
`endif

    logic          clk;
    logic          rst_n;
    logic          start;
    logic          pause;
    logic          abort;
    logic [TW-1:0] wash_time;
    logic [1:0]    motor;
    logic          compl_n;
    logic          busy;
    logic [TW-1:0] remain;

    wash_seq_ctrl #(
        .CLK_HZ (CLK_HZ),
        .TW     (TW),
        .FWD_S  (FWD_S),
        .STOP_S (STOP_S),
        .REV_S  (REV_S),
        .SPIN_S (SPIN_S)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .pause     (pause),
        .abort     (abort),
        .wash_time (wash_time),
        .motor     (motor),
        .compl_n   (compl_n),
        .busy      (busy),
        .remain    (remain)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Reference model state
    logic          m_active;
    logic          m_prev_start;
    int            m_n;
    int            m_w;
    logic [1:0]    m_motor;
    logic          m_compl;
    logic          m_busy;
    logic [TW-1:0] m_remain;

    logic [TW+3:0] dut_vec;
    logic [TW+3:0] exp_vec;
    assign dut_vec = {motor, compl_n, busy, remain};
    assign exp_vec = {m_motor, m_compl, m_busy, m_remain};

    task automatic model_reset();
        m_active = 1'b0; m_prev_start = 1'b0; m_n = 0; m_w = 0;
        m_motor = 2'b00; m_compl = 1'b1; m_busy = 1'b0; m_remain = '0;
    endtask

    // Advances the model by one clock using the inputs present at the edge.
    task automatic model_step();
        int   s;
        int   p;
        logic rise;
        rise = start && !m_prev_start;
        m_prev_start = start;
        if (abort) begin
            m_active = 1'b0; m_motor = 2'b00; m_remain = '0; m_busy = 1'b0; m_compl = 1'b1;
            return;
        end
        if (!m_active) begin
            if (rise && wash_time != '0) begin
                m_active = 1'b1; m_n = 0; m_w = int'(wash_time);
            end else begin
                return;
            end
        end else if (!pause) begin
            m_n++;
        end
        s = m_n / CLK_HZ;
        if (s >= m_w + SPIN_LEN) begin
            m_active = 1'b0; m_motor = 2'b00; m_remain = '0; m_busy = 1'b0; m_compl = 1'b0;
        end else begin
            m_busy = 1'b1; m_compl = 1'b1;
            if (s >= m_w) begin
                m_remain = '0; m_motor = 2'b11;
            end else begin
                m_remain = TW'(m_w - s);
                p = s % CYC_S;
                if (p < FWD_S)                       m_motor = 2'b01;
                else if (p < FWD_S + STOP_S)         m_motor = 2'b00;
                else if (p < FWD_S + STOP_S + REV_S) m_motor = 2'b10;
                else                                 m_motor = 2'b00;
            end
            if (pause) m_motor = 2'b00;
        end
    endtask

    // One clock: model follows the edge, caller samples at the falling edge.
    task automatic clk_step();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        model_reset();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        start = 1'b0; pause = 1'b0; abort = 1'b0; wash_time = '0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        model_reset();
        tests++;
        if (motor !== 2'b00) begin fails++; $display("FAIL reset_motor: got %b exp 00", motor); end
        tests++;
        if (compl_n !== 1'b1) begin fails++; $display("FAIL reset_compl_n: got %b exp 1", compl_n); end
        tests++;
        if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b exp 0", busy); end
        tests++;
        if (remain !== '0) begin fails++; $display("FAIL reset_remain: got %0d exp 0", remain); end
        rst_n = 1'b1;
        clk_step();
        tests++;
        if (dut_vec !== exp_vec) begin fails++; $display("FAIL reset_idle: got %h exp %h", dut_vec, exp_vec); end
    endtask

    task automatic test_full_run();
        int  k;
        bit  seen_spin;
        wash_time = 12; start = 1'b1;
        clk_step();
        start = 1'b0;
        tests++;
        if (dut_vec !== exp_vec) begin fails++; $display("FAIL run_accept: got %h exp %h", dut_vec, exp_vec); end
        k = 0; seen_spin = 0;
        while (compl_n !== 1'b0 && k < 200) begin
            clk_step();
            k++;
            if (motor === 2'b11) seen_spin = 1;
            tests++;
            if (dut_vec !== exp_vec) begin fails++; $display("FAIL run_cyc%0d: got %h exp %h", k, dut_vec, exp_vec); end
        end
        tests++;
        if (k !== 48 + SPIN_LEN * CLK_HZ) begin
            fails++; $display("FAIL run_done_clk: got %0d exp %0d", k, 48 + SPIN_LEN * CLK_HZ);
        end
        tests++;
        if (seen_spin !== (SPIN_LEN > 0)) begin
            fails++; $display("FAIL run_spin_seen: got %0d exp %0d", seen_spin, SPIN_LEN > 0);
        end
        repeat (3) clk_step();
        tests++;
        if (compl_n !== 1'b0 || busy !== 1'b0) begin
            fails++; $display("FAIL run_done_hold: got compl_n=%b busy=%b exp 0 0", compl_n, busy);
        end
    endtask

    task automatic test_pause();
        int            pre, post, k;
        logic [TW-1:0] frozen;
        wash_time = 12; start = 1'b1;
        clk_step();
        start = 1'b0;
        pre = (motor === 2'b01) ? 1 : 0;
        for (int i = 1; i < 5; i++) begin
            clk_step();
            if (motor === 2'b01) pre++;
        end
        tests++;
        if (pre !== 5) begin fails++; $display("FAIL pause_pre_fwd: got %0d exp 5", pre); end
        frozen = remain;
        pause = 1'b1;
        for (int i = 0; i < 10; i++) begin
            clk_step();
            tests++;
            if (dut_vec !== exp_vec || motor !== 2'b00 || remain !== frozen) begin
                fails++; $display("FAIL pause_hold%0d: got %h exp %h", i, dut_vec, exp_vec);
            end
        end
        pause = 1'b0;
        post = 0; k = 0;
        do begin
            clk_step();
            k++;
            if (motor === 2'b01) post++;
            tests++;
            if (dut_vec !== exp_vec) begin fails++; $display("FAIL pause_resume%0d: got %h exp %h", k, dut_vec, exp_vec); end
        end while (motor === 2'b01 && k < 20);
        tests++;
        if (post !== 3) begin fails++; $display("FAIL pause_post_fwd: got %0d exp 3", post); end
        tests++;
        if (motor !== 2'b00 || busy !== 1'b1) begin
            fails++; $display("FAIL pause_stop1: got motor=%b busy=%b exp 00 1", motor, busy);
        end
        abort = 1'b1; clk_step(); abort = 1'b0;
    endtask

    task automatic test_abort();
        wash_time = 12; start = 1'b1;
        clk_step();
        for (int i = 1; i < 20; i++) clk_step();
        abort = 1'b1;
        clk_step();
        abort = 1'b0;
        tests++;
        if (motor !== 2'b00 || remain !== '0 || busy !== 1'b0 || compl_n !== 1'b1) begin
            fails++; $display("FAIL abort_idle: got motor=%b remain=%0d busy=%b compl_n=%b exp 00 0 0 1",
                              motor, remain, busy, compl_n);
        end
        for (int i = 0; i < 10; i++) begin
            clk_step();
            tests++;
            if (dut_vec !== exp_vec || busy !== 1'b0) begin
                fails++; $display("FAIL abort_no_restart%0d: got %h exp %h", i, dut_vec, exp_vec);
            end
        end
        start = 1'b0;
        clk_step();
    endtask

    task automatic test_ignored_start();
        wash_time = 0; start = 1'b1;
        clk_step();
        start = 1'b0;
        tests++;
        if (busy !== 1'b0 || motor !== 2'b00) begin
            fails++; $display("FAIL zero_time_start: got busy=%b motor=%b exp 0 00", busy, motor);
        end
        clk_step();
        wash_time = 5; start = 1'b1;
        clk_step();
        start = 1'b0;
        clk_step();
        wash_time = 9; start = 1'b1;
        clk_step();
        start = 1'b0;
        tests++;
        if (remain !== TW'(5) || busy !== 1'b1 || dut_vec !== exp_vec) begin
            fails++; $display("FAIL busy_start_reload: got remain=%0d busy=%b exp remain=5 busy=1", remain, busy);
        end
        for (int i = 0; i < 30; i++) begin
            clk_step();
            tests++;
            if (dut_vec !== exp_vec) begin fails++; $display("FAIL busy_start_run%0d: got %h exp %h", i, dut_vec, exp_vec); end
        end
        abort = 1'b1; clk_step(); abort = 1'b0;
    endtask

    task automatic test_reset_async();
        wash_time = 12; start = 1'b1;
        clk_step();
        start = 1'b0;
        for (int i = 0; i < 14; i++) clk_step();
        tests++;
        if (motor !== 2'b10) begin fails++; $display("FAIL rst_pre_rev: got %b exp 10", motor); end
        #2 rst_n = 1'b0;
        #1;
        tests++;
        if (motor !== 2'b00 || compl_n !== 1'b1 || busy !== 1'b0 || remain !== '0) begin
            fails++; $display("FAIL rst_mid_rev: got motor=%b compl_n=%b busy=%b remain=%0d exp 00 1 0 0",
                              motor, compl_n, busy, remain);
        end
        @(negedge clk);
        model_reset();
        rst_n = 1'b1;
        wash_time = 1; start = 1'b1;
        clk_step();
        start = 1'b0;
        repeat (CLK_HZ * (1 + SPIN_LEN)) clk_step();
        tests++;
        if (compl_n !== 1'b0) begin fails++; $display("FAIL rst_done_pre: got compl_n=%b exp 0", compl_n); end
        #2 rst_n = 1'b0;
        #1;
        tests++;
        if (compl_n !== 1'b1) begin fails++; $display("FAIL rst_in_done: got compl_n=%b exp 1", compl_n); end
        @(negedge clk);
        model_reset();
        rst_n = 1'b1;
    endtask

    task automatic test_random();
        for (int i = 0; i < 800; i++) begin
            start     = ($urandom_range(0, 3) == 0);
            wash_time = TW'($urandom_range(0, 5));
            pause     = ($urandom_range(0, 9) == 0);
            abort     = ($urandom_range(0, 49) == 0);
            clk_step();
            tests++;
            if (dut_vec !== exp_vec) begin fails++; $display("FAIL random%0d: got %h exp %h", i, dut_vec, exp_vec); end
        end
        start = 1'b0; pause = 1'b0; abort = 1'b0;
    endtask

    initial begin
        model_reset();
        test_reset();
        test_full_run();
        test_pause();
        test_abort();
        test_ignored_start();
        test_reset_async();
        do_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/wash_seq_ctrl.md
WASH_SEQ_CTRL -- requirements
Module: wash_seq_ctrl

Interface
REQ-001 SHALL have parameter CLK_HZ, default 40000; clk cycles per one-second tick.
REQ-002 SHALL have parameter TW, default 12; width of wash_time and remain (seconds).
REQ-003 SHALL have parameter FWD_S, default 20; forward-run phase length in seconds.
REQ-004 SHALL have parameter STOP_S, default 10; pause length between direction changes in seconds.
REQ-005 SHALL have parameter REV_S, default 20; reverse-run phase length in seconds.
REQ-006 SHALL have parameter SPIN_S, default 30; final spin length in seconds (used only with WASH_SPIN_EN).
REQ-007 SHALL have port clk  input  1  single system clock; all state on its rising edge.
REQ-008 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-009 SHALL have port start  input  1  run request; only its rising edge counts.
REQ-010 SHALL have port pause  input  1  level; freezes the run while high.
REQ-011 SHALL have port abort  input  1  level; cancels the run.
REQ-012 SHALL have port wash_time  input  TW  total wash seconds, sampled on the accepted start edge.
REQ-013 SHALL have port motor  output  2  00 stop, 01 forward, 10 reverse, 11 spin.
REQ-014 SHALL have port compl_n  output  1  active-low completion flag.
REQ-015 SHALL have port busy  output  1  high in any state other than IDLE/DONE.
REQ-016 SHALL have port remain  output  TW  seconds of wash left.

Function
REQ-017 SHALL implement states IDLE, FWD, STOP1, REV, STOP2, SPIN, DONE; all outputs registered.
REQ-018 SHALL accept start when a rising edge is seen in IDLE or DONE with wash_time != 0: the next cycle is FWD, remain=wash_time, phase counter=FWD_S, prescaler=0, compl_n=1.
REQ-019 SHALL ignore a start edge when wash_time == 0 or while busy.
REQ-020 SHALL generate one tick per CLK_HZ unpaused clocks in FWD..SPIN; each tick decrements the phase counter and, outside SPIN, remain.
REQ-021 SHALL advance FWD->STOP1->REV->STOP2->FWD on the tick where the phase counter is 1, reloading it with the next phase length.
REQ-022 SHALL, on the tick where remain is 1, go to SPIN (with WASH_SPIN_EN) or DONE, regardless of the current phase.
REQ-023 SHALL drive motor 00 in IDLE, STOP1, STOP2, DONE and while paused; 01 in FWD; 10 in REV; 11 in SPIN.
REQ-024 SHALL, while pause is high, hold state, phase counter, remain and prescaler; the run resumes exactly where it stopped.
REQ-025 SHALL, while abort is high, go to IDLE the next cycle: motor 00, remain 0, compl_n 1; abort takes priority over start and pause.
REQ-026 SHALL hold compl_n low in DONE until the next accepted start or abort.

Reset
REQ-027 SHALL, while rst_n is low, force state IDLE, motor 00, compl_n 1, busy 0, remain 0, and clear all counters and the start-edge register, mid-run included.

Configuration
REQ-028 SHALL, with WASH_SPIN_EN defined, include state SPIN for SPIN_S ticks (motor 11) between the last wash tick and DONE.
REQ-029 SHALL, without WASH_SPIN_EN, go directly to DONE and never drive motor 11.

Structure
REQ-030 SHALL place the state encoding and motor codes (MOTOR_STOP, MOTOR_FWD, MOTOR_REV, MOTOR_SPIN) in shared package wash_pkg.
REQ-031 SHALL implement the prescaler as sub-module sec_tick (parameter CLK_HZ; inputs clr and en; output tick).

Verification (sim params: CLK_HZ=4, FWD_S=2, STOP_S=1, REV_S=2, SPIN_S=3)
REQ-032 SHALL check this case: wash_time=12, start pulse -> motor follows 01 x8, 00 x4, 10 x8, 00 x4 clks, repeated twice; then DONE with compl_n 0 at clk 48 (spin off).
REQ-033 SHALL check the same run with WASH_SPIN_EN -> motor 11 for 12 clks after clk 48 while remain holds 0, then compl_n 0.
REQ-034 SHALL check this case: pause high for 10 clks at clk 5 of FWD -> motor 00, remain frozen; after pause falls, 3 more FWD clks, then STOP1.
REQ-035 SHALL check this case: abort at clk 20 -> next cycle IDLE, motor 00, remain 0, busy 0, compl_n 1; a start held high through abort gives no restart.
REQ-036 SHALL check this case: start edge with wash_time=0 -> stays IDLE; start edge while busy -> no reload of remain.
REQ-037 SHALL check this case: rst_n low mid-REV -> motor 00 and compl_n 1 immediately, without waiting for clk.
